// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit on a word-only data memory
module load_store_unit #(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DMEM_WORDS);

    state_t      state, state_next;
    logic        lat_write;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr, lat_wdata, merged;
    logic        accept, req_illegal, req_misaligned, req_range, req_fault;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, merge_word;

    assign accept = (state == IDLE) && req_valid;

    // Request checks are made on the live inputs so a fault never reaches memory
    always_comb begin
        req_illegal    = req_write ? (req_funct3 > 3'b010)
                                   : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        req_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                         (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        req_range      = {1'b0, req_addr} >= ADDR_LIMIT;
        req_fault      = req_illegal || req_misaligned || req_range;
    end

    always_comb begin
        ld_byte = mem_read_data[{lat_addr[1:0], 3'b000} +: 8];
        ld_half = lat_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (lat_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_read_data;
        endcase
    end

    always_comb begin
        merge_word = mem_read_data;
        if (lat_funct3[1:0] == 2'b00)
            merge_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
        else
            merge_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault)                 state_next = RESP;
                    else if (!req_write)           state_next = LOAD;
                    else if (req_funct3 == 3'b010) state_next = WRITE;
                    else                           state_next = RMW_READ;
                end
            end
            LOAD:     state_next = RESP;
            RMW_READ: state_next = WRITE;
            WRITE:    state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
            lat_write  <= 1'b0;
            lat_funct3 <= 3'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            merged     <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_write  <= req_write;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                resp_fault <= req_fault;
                if (req_write || req_fault)
                    resp_rdata <= 32'h0;
            end
            if (state == LOAD)
                resp_rdata <= ld_ext;
            if (state == RMW_READ)
                merged <= merge_word;
        end
    end

    // Handshake and memory strobes are gated by rst so a reset never leaks a write
    always_comb begin
        req_ready      = !rst && (state == IDLE);
        resp_valid     = !rst && (state == RESP);
        mem_read       = !rst && (state == LOAD || state == RMW_READ);
        mem_write      = !rst && (state == WRITE);
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        if (state == LOAD || state == RMW_READ || state == WRITE)
            mem_address = {lat_addr[31:2], 2'b00};
        if (state == WRITE)
            mem_write_data = (lat_write && lat_funct3 == 3'b010) ? lat_wdata : merged;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] dmem [0:255];
    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DMEM_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = dmem[mem_address[9:2]];
    always @(posedge clk)
        if (mem_write) dmem[mem_address[9:2]] <= mem_write_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] rdata, input logic fault,
                        input int lat, input int nrd, input int nwr);
        exp_t e;
        e.tag = tag; e.rdata = rdata; e.fault = fault;
        e.lat = lat; e.nrd = nrd; e.nwr = nwr;
        sb_q.push_back(e);
    endtask

    // Wait for the response, tallying memory strobes, then pop and compare
    task automatic collect(input bit check_busy);
        exp_t e;
        int lat = 0, nrd = 0, nwr = 0;
        bit got = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (check_busy) check("busy_ready", {31'h0, req_ready}, 32'h0);
            got = resp_valid;
        end
        e = sb_q.pop_front();
        check({e.tag, "_timeout"}, {31'h0, got}, 32'h1);
        check({e.tag, "_rdata"}, resp_rdata, e.rdata);
        check({e.tag, "_fault"}, {31'h0, resp_fault}, {31'h0, e.fault});
        check({e.tag, "_lat"}, lat, e.lat);
        check({e.tag, "_nrd"}, nrd, e.nrd);
        check({e.tag, "_nwr"}, nwr, e.nwr);
    endtask

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
    endtask

    task automatic issue(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_fault,
                         input int exp_lat, input int nrd, input int nwr);
        @(negedge clk);
        drive(wr, f3, addr, wdata);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        push(tag, exp_rdata, exp_fault, exp_lat, nrd, nwr);
        @(posedge clk);
        #1 req_valid = 1'b0;
        collect(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_memrd", {31'h0, mem_read}, 32'h0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_fault", {31'h0, resp_fault}, 32'h0);
        check("reset_valid", {31'h0, resp_valid}, 32'h0);

        issue("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1);
        issue("lw10",  0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0);
        issue("lb13",  0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 0);
        issue("lbu13", 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 2, 1, 0);
        issue("lh12",  0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 0);
        issue("lhu12", 0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 0, 2, 1, 0);
        issue("lb10",  0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 2, 1, 0);
        issue("sb11",  1, 3'b000, 32'h11, 32'h12345677, 32'h0,        0, 3, 1, 1);
        issue("lw_sb", 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0, 2, 1, 0);
        issue("sh12",  1, 3'b001, 32'h12, 32'hAAAA5555, 32'h0,        0, 3, 1, 1);
        issue("lw_sh", 0, 3'b010, 32'h10, 32'h0,        32'h555577EF, 0, 2, 1, 0);

        issue("f_lh11",  0, 3'b001, 32'h11,  32'h0, 32'h0, 1, 1, 0, 0);
        issue("f_lw12",  0, 3'b010, 32'h12,  32'h0, 32'h0, 1, 1, 0, 0);
        issue("f_ld011", 0, 3'b011, 32'h10,  32'h0, 32'h0, 1, 1, 0, 0);
        issue("f_lw400", 0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 1, 0, 0);
        issue("f_st100", 1, 3'b100, 32'h10,  32'h1, 32'h0, 1, 1, 0, 0);
        issue("sw3fc",   1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1);
        issue("lw3fc",   0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0);
        issue("lhu3fe",  0, 3'b101, 32'h3FE, 32'h0,        32'h0000CAFE, 0, 2, 1, 0);

        // Back-to-back: valid held high, second request waits until after RESP
        @(negedge clk);
        drive(0, 3'b010, 32'h10, 32'h0);
        push("b2b_a", 32'h555577EF, 0, 2, 1, 0);
        @(posedge clk);
        #1 drive(0, 3'b000, 32'h3FF, 32'h0);
        push("b2b_b", 32'hFFFFFFCA, 0, 2, 1, 0);
        collect(1'b1);
        @(negedge clk);
        check("b2b_ready_after", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        collect(1'b0);

        // Reset during WRITE of an SB: no write, no response
        @(negedge clk);
        drive(1, 3'b000, 32'h10, 32'h99);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_read", {31'h0, mem_read}, 32'h1);
        @(negedge clk);
        check("write_state", {31'h0, mem_write}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_wr_gate", {31'h0, mem_write}, 32'h0);
        check("rst_rv_gate", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        check("rst_hold_valid", {31'h0, resp_valid}, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_rdata", resp_rdata, 32'h0);
        check("post_rst_fault", {31'h0, resp_fault}, 32'h0);
        check("post_rst_valid", {31'h0, resp_valid}, 32'h0);
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_memwr", {31'h0, mem_write}, 32'h0);
        issue("lw_prev", 0, 3'b010, 32'h10, 32'h0, 32'h555577EF, 0, 2, 1, 0);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the core's execute stage and the word-organised data memory, sitting directly upstream of the memory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the memory's memread/memwrite/address/write_data/read_data interface.
- Sign- or zero-extends loaded sub-words and performs read-modify-write for sub-word stores, because the memory writes whole words only.
- Flags misaligned, illegal and out-of-range requests without touching memory.

Parameters:
- DMEM_WORDS, 256, number of 32-bit words in data memory; byte addresses at or above 4*DMEM_WORDS fault.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the load/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2), right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load result; 0 for stores and faults
- resp_fault  out  1  valid with resp_valid: misaligned, illegal funct3 or out of range
- mem_read  out  1  drives the memory's memread
- mem_write  out  1  drives the memory's memwrite
- mem_address  out  32  word-aligned byte address, bits [1:0] = 0
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data from memory, valid in the same cycle as mem_read

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - FSM in IDLE.
  - resp_rdata=0, resp_fault=0, resp_valid=0.
  - While rst is high: req_ready=0, mem_read=0 and mem_write=0, gated combinationally regardless of state.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP. Outputs are decoded from state and the latched request.
- IDLE:
  - req_ready=1; all mem_* outputs 0.
  - On req_valid, latch write, funct3, addr and wdata.
  - Fault cases go to RESP with fault=1:
    - illegal: load funct3 in {011,110,111}, or store funct3 not in {000,001,010};
    - misaligned: H access with addr[0]=1, or W access with addr[1:0]!=0;
    - out of range: addr >= 4*DMEM_WORDS.
  - Otherwise: load -> LOAD; SW -> WRITE; SB/SH -> RMW_READ.
- LOAD:
  - mem_read=1, mem_address={addr[31:2],2'b00}.
  - Select byte addr[1:0] or half addr[1], extend (sign for LB/LH, zero for LBU/LHU), register into resp_rdata.
  - Go to RESP.
- RMW_READ:
  - mem_read=1.
  - Register mem_read_data with the target byte/half lane replaced by wdata[7:0] or wdata[15:0].
  - Go to WRITE.
- WRITE:
  - mem_write=1, mem_address as in LOAD.
  - mem_write_data = wdata (SW) or the merged word (SB/SH).
  - Go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0; then go to IDLE.
  - For stores and faults, resp_rdata is set to 0 when the request is latched.
- Timing:
  - No back-to-back acceptance; the next request can be accepted the cycle after RESP.
  - Latency from the accept edge to resp_valid: fault 1 cycle, LW/LB/LH 2, SW 2, SB/SH 3.
- Data stability: resp_rdata and resp_fault hold until the next response is produced.
- Reset mid-operation:
  - The in-flight request is dropped and no response is issued.
  - A WRITE-state cycle with rst high produces no memory write.
- req_valid is ignored outside IDLE, and req_* inputs are not sampled after acceptance.
- Only addr[31:2] reaches memory; the memory sees no sub-word enables.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> one mem_write cycle, then resp_rdata=0xDEADBEEF with resp_valid 2 cycles after accept.
- With word 0x10 = 0xDEADBEEF, issue LB 0x13, LBU 0x13, LH 0x12, LHU 0x12 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
- SB 0x11 wdata 0x12345677, then LW 0x10 -> 0xDEAD77EF. SH 0x12 wdata 0xAAAA5555, then LW -> 0x555577EF. Each SB/SH shows a 3-cycle latency and exactly one mem_write.
- Faults: LH 0x11, LW 0x12, load funct3=011, and LW 0x400 with DMEM_WORDS=256 -> each gives resp_fault=1, resp_rdata=0, 1-cycle latency, no mem_read/mem_write.
- Hold req_valid high with back-to-back requests -> req_ready low from accept until RESP completes; the second request is accepted only in the cycle after resp_valid.
- Assert rst during the WRITE state of an SB -> no mem_write pulse, no resp_valid; after reset, LW of that word returns the pre-store value and all outputs are at reset values.
